fc_event_collector: RTL and testbench



---
 rtl/fc_evt_pkg.sv | 11 +
 rtl/fc_evt_rr_arbiter.sv | 52 +++++
 rtl/fc_event_collector.sv | 125 ++++++++++++
 tb/tb_fc_event_collector.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_evt_pkg.sv
// Shared constants and types for the fabric-controller event collector.
package fc_evt_pkg;

    localparam int NB_EVENTS_DEF      = 160;
    localparam int EVENT_ID_WIDTH_DEF = 8;
    localparam int FIFO_DEPTH_DEF     = 4;
    localparam int LOST_CNT_W         = 16;

    typedef logic [EVENT_ID_WIDTH_DEF-1:0] evt_id_t;

endpackage

// File: rtl/fc_evt_rr_arbiter.sv
// Round-robin arbiter: one grant per cycle, search starts one past the last winner.
// Combinational grant; pointer updates on the granting edge; no grant while i_gnt_en is low.
module fc_evt_rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic [N-1:0]   i_req,
    input  logic           i_gnt_en,
    output logic           o_gnt_vld,
    output logic [N-1:0]   o_gnt_oh,
    output logic [IDW-1:0] o_gnt_idx
);

    logic [IDW-1:0] r_ptr;
    logic           w_hi_vld;
    logic           w_lo_vld;
    logic [IDW-1:0] w_hi_idx;
    logic [IDW-1:0] w_lo_idx;

    // Lowest request at/above the pointer wins; otherwise wrap to the lowest overall.
    always_comb begin
        w_hi_vld = 1'b0;
        w_hi_idx = '0;
        w_lo_vld = 1'b0;
        w_lo_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                w_lo_vld = 1'b1;
                w_lo_idx = IDW'(i);
                if (IDW'(i) >= r_ptr) begin
                    w_hi_vld = 1'b1;
                    w_hi_idx = IDW'(i);
                end
            end
        end
    end

    assign o_gnt_vld = i_gnt_en & w_lo_vld;
    assign o_gnt_idx = w_hi_vld ? w_hi_idx : w_lo_idx;
    assign o_gnt_oh  = o_gnt_vld ? (N'(1) << o_gnt_idx) : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (o_gnt_vld) begin
            r_ptr <= (o_gnt_idx == IDW'(N - 1)) ? '0 : o_gnt_idx + IDW'(1);
        end
    end

endmodule

// File: rtl/fc_event_collector.sv
// Captures event pulses into pending bits, round-robins them into a small ID FIFO for the FC.
// Latency: pulse at t -> event_valid_o at t+2. Backpressure: full FIFO stalls grants, pending holds;
// only repeat pulses on a pending source are lost. FC_EVT_LOST_CNT_EN adds a saturating lost counter.
module fc_event_collector
    import fc_evt_pkg::*;
#(
    parameter int NB_EVENTS      = NB_EVENTS_DEF,
    parameter int EVENT_ID_WIDTH = EVENT_ID_WIDTH_DEF,
    parameter int FIFO_DEPTH     = FIFO_DEPTH_DEF
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      enable_i,
    input  logic [NB_EVENTS-1:0]      events_i,
    output logic                      event_valid_o,
    output logic [EVENT_ID_WIDTH-1:0] event_data_o,
    input  logic                      event_ready_i,
    output logic [NB_EVENTS-1:0]      pending_o,
`ifdef FC_EVT_LOST_CNT_EN
    output logic [LOST_CNT_W-1:0]     lost_cnt_o,
    input  logic                      lost_cnt_clr_i,
`endif
    output logic                      lost_evt_o
);

    localparam int IDW = (NB_EVENTS > 1) ? $clog2(NB_EVENTS) : 1;
    localparam int PW  = $clog2(FIFO_DEPTH);

    logic [NB_EVENTS-1:0]      r_pending;
    logic                      r_lost;
    logic [EVENT_ID_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]             r_wr_ptr;
    logic [PW-1:0]             r_rd_ptr;
    logic [PW:0]               r_count;
    logic [EVENT_ID_WIDTH-1:0] r_last;

    logic                      w_gnt_vld;
    logic [NB_EVENTS-1:0]      w_gnt_oh;
    logic [IDW-1:0]            w_gnt_idx;
    logic [NB_EVENTS-1:0]      w_capture;
    logic [NB_EVENTS-1:0]      w_lost_vec;
    logic                      w_lost;
    logic                      w_full;
    logic                      w_pop;

    assign w_full    = (r_count == (PW+1)'(FIFO_DEPTH));
    assign w_pop     = event_valid_o & event_ready_i;
    assign w_capture = enable_i ? events_i : '0;
    // A repeat pulse is only lost if the bit is not being cleared this same cycle.
    assign w_lost_vec = w_capture & r_pending & ~w_gnt_oh;
    assign w_lost     = |w_lost_vec;

    fc_evt_rr_arbiter #(
        .N   (NB_EVENTS),
        .IDW (IDW)
    ) u_arb (
        .i_clk     (clk_i),
        .i_rst_n   (rst_ni),
        .i_req     (r_pending),
        .i_gnt_en  (~w_full | w_pop),
        .o_gnt_vld (w_gnt_vld),
        .o_gnt_oh  (w_gnt_oh),
        .o_gnt_idx (w_gnt_idx)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pending <= '0;
            r_lost    <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_gnt_oh) | w_capture;
            r_lost    <= w_lost;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_gnt_vld) begin
            r_mem[r_wr_ptr] <= EVENT_ID_WIDTH'(w_gnt_idx);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_last   <= '0;
        end else begin
            if (w_gnt_vld) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
                r_last   <= r_mem[r_rd_ptr];
            end
            case ({w_gnt_vld, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign event_valid_o = (r_count != '0);
    assign event_data_o  = event_valid_o ? r_mem[r_rd_ptr] : r_last;
    assign pending_o     = r_pending;
    assign lost_evt_o    = r_lost;

`ifdef FC_EVT_LOST_CNT_EN
    logic [LOST_CNT_W-1:0] r_lost_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lost_cnt <= '0;
        end else if (lost_cnt_clr_i) begin
            r_lost_cnt <= LOST_CNT_W'(w_lost);
        end else if (w_lost && (r_lost_cnt != '1)) begin
            r_lost_cnt <= r_lost_cnt + LOST_CNT_W'(1);
        end
    end

    assign lost_cnt_o = r_lost_cnt;
`endif

endmodule

// File: tb/tb_fc_event_collector.sv
// Bench for fc_event_collector: directed scenarios plus a randomized run against a queue-based model.
module tb_fc_event_collector;
    import fc_evt_pkg::*;

    localparam int NB    = 160;
    localparam int IDW   = 8;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            en = 1'b1;
    logic            ready = 1'b1;
    logic [NB-1:0]   ev = '0;
    logic            valid;
    logic [IDW-1:0]  data;
    logic [NB-1:0]   pending;
    logic            lost;
    logic            lost_clr = 1'b0;
`ifdef FC_EVT_LOST_CNT_EN
    logic [15:0]     lost_cnt;
`endif

    int checks = 0;
    int errors = 0;

    bit m_pend [NB];
    int m_ptr;
    int m_q [$];
    int m_last;
    bit m_lost;
    int m_cnt;

    always #5 clk = ~clk;

    fc_event_collector dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .enable_i      (en),
        .events_i      (ev),
        .event_valid_o (valid),
        .event_data_o  (data),
        .event_ready_i (ready),
        .pending_o     (pending),
`ifdef FC_EVT_LOST_CNT_EN
        .lost_cnt_o    (lost_cnt),
        .lost_cnt_clr_i(lost_clr),
`endif
        .lost_evt_o    (lost)
    );

    task automatic model_reset();
        for (int i = 0; i < NB; i++) m_pend[i] = 1'b0;
        m_ptr = 0;
        m_q.delete();
        m_last = 0;
        m_lost = 1'b0;
        m_cnt = 0;
    endtask

    // One clock of the reference: decide pop, pick the winner by scanning from the pointer, apply.
    task automatic model_eval();
        bit pop, can, lost_now;
        int g;
        pop = (m_q.size() > 0) && ready;
        can = (m_q.size() < DEPTH) || pop;
        g = -1;
        if (can)
            for (int k = 0; k < NB; k++)
                if (g < 0 && m_pend[(m_ptr + k) % NB]) g = (m_ptr + k) % NB;
        lost_now = 1'b0;
        if (en)
            for (int i = 0; i < NB; i++)
                if (ev[i] && m_pend[i] && i != g) lost_now = 1'b1;
        if (pop) m_last = m_q.pop_front();
        if (g >= 0) begin
            m_q.push_back(g);
            m_pend[g] = 1'b0;
            m_ptr = (g + 1) % NB;
        end
        if (en)
            for (int i = 0; i < NB; i++)
                if (ev[i]) m_pend[i] = 1'b1;
        m_lost = lost_now;
        if (lost_clr) m_cnt = lost_now ? 1 : 0;
        else if (lost_now && m_cnt < 65535) m_cnt++;
    endtask

    function automatic logic [NB-1:0] model_pend_vec();
        logic [NB-1:0] v;
        v = '0;
        for (int i = 0; i < NB; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic step();
        if (!rst_n) model_reset();
        else model_eval();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ev = '0;
        rst_n = 1'b0;
        model_reset();
        #1;
        step();
        rst_n = 1'b1;
        ready = 1'b1;
        en = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        step();
        step();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
        checks++; if (data !== 8'd0) begin errors++; $display("FAIL reset_data: got %0d want 0", data); end
        checks++; if (pending !== '0) begin errors++; $display("FAIL reset_pending: got %h want 0", pending); end
        checks++; if (lost !== 1'b0) begin errors++; $display("FAIL reset_lost: got %b want 0", lost); end
`ifdef FC_EVT_LOST_CNT_EN
        checks++; if (lost_cnt !== 16'd0) begin errors++; $display("FAIL reset_lost_cnt: got %0d want 0", lost_cnt); end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [NB-1:0] exp_p;
        exp_p = '0;
        exp_p[37] = 1'b1;
        ready = 1'b1;
        ev[37] = 1'b1;
        step();
        ev = '0;
        checks++; if (pending !== exp_p) begin errors++; $display("FAIL single_pending_set: got %h want %h", pending, exp_p); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b want 0", valid); end
        step();
        checks++; if (valid !== 1'b1 || data !== 8'd37) begin errors++; $display("FAIL single_out: got v=%b d=%0d want v=1 d=37", valid, data); end
        checks++; if (pending !== '0) begin errors++; $display("FAIL single_pending_clr: got %h want 0", pending); end
        step();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL single_one_cycle: got %b want 0", valid); end
    endtask

    task automatic test_fairness();
        int seq_a [3] = '{5, 6, 100};
        int seq_b [2] = '{7, 5};
        do_reset();
        ev[5] = 1'b1; ev[6] = 1'b1; ev[100] = 1'b1;
        step();
        ev = '0;
        step();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (valid !== 1'b1 || data !== IDW'(seq_a[k])) begin
                errors++; $display("FAIL fair_a[%0d]: got v=%b d=%0d want v=1 d=%0d", k, valid, data, seq_a[k]);
            end
            step();
        end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL fair_a_end: got %b want 0", valid); end
        do_reset();
        ev[5] = 1'b1;
        step();
        ev = '0;
        step();
        step();
        ev[5] = 1'b1; ev[7] = 1'b1;
        step();
        ev = '0;
        step();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (valid !== 1'b1 || data !== IDW'(seq_b[k])) begin
                errors++; $display("FAIL fair_b[%0d]: got v=%b d=%0d want v=1 d=%0d", k, valid, data, seq_b[k]);
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        int lost_seen = 0;
        logic [NB-1:0] exp_p;
        exp_p = '0;
        exp_p[5:4] = 2'b11;
        do_reset();
        ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ev = '0;
            ev[i] = 1'b1;
            step();
            lost_seen += int'(lost);
        end
        ev = '0;
        step(); lost_seen += int'(lost);
        step(); lost_seen += int'(lost);
        checks++; if (pending !== exp_p) begin errors++; $display("FAIL bp_pending: got %h want %h", pending, exp_p); end
        checks++; if (valid !== 1'b1 || data !== 8'd0) begin errors++; $display("FAIL bp_head: got v=%b d=%0d want v=1 d=0", valid, data); end
        ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (valid !== 1'b1 || data !== IDW'(k)) begin
                errors++; $display("FAIL bp_drain[%0d]: got v=%b d=%0d want v=1 d=%0d", k, valid, data, k);
            end
            step();
            lost_seen += int'(lost);
        end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b want 0", valid); end
        checks++; if (lost_seen !== 0) begin errors++; $display("FAIL bp_lost: got %0d pulses want 0", lost_seen); end
    endtask

    task automatic test_lost();
        int got [$];
        int exp_q [5] = '{0, 1, 2, 3, 9};
        do_reset();
        ready = 1'b0;
        ev[3:0] = 4'hF;
        step();
        ev = '0;
        repeat (5) step();
        ev[9] = 1'b1;
        step();
        ev = '0;
        checks++; if (lost !== 1'b0) begin errors++; $display("FAIL lost_first: got %b want 0", lost); end
        ev[9] = 1'b1;
        step();
        ev = '0;
        checks++; if (lost !== 1'b1) begin errors++; $display("FAIL lost_pulse: got %b want 1", lost); end
`ifdef FC_EVT_LOST_CNT_EN
        checks++; if (lost_cnt !== 16'd1) begin errors++; $display("FAIL lost_cnt: got %0d want 1", lost_cnt); end
`endif
        step();
        checks++; if (lost !== 1'b0) begin errors++; $display("FAIL lost_single: got %b want 0", lost); end
        ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (valid === 1'b1) got.push_back(int'(data));
            step();
        end
        checks++;
        if (got.size() !== 5) begin
            errors++; $display("FAIL lost_drain_len: got %0d want 5", got.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (got[k] !== exp_q[k]) begin errors++; $display("FAIL lost_drain[%0d]: got %0d want %0d", k, got[k], exp_q[k]); end
            end
        end
    endtask

    task automatic test_collision();
        int n3 = 0;
        int lost_seen = 0;
        do_reset();
        ev[3] = 1'b1;
        step();
        step();
        lost_seen += int'(lost);
        ev = '0;
        for (int k = 0; k < 8; k++) begin
            if (valid === 1'b1 && data === 8'd3) n3++;
            step();
            lost_seen += int'(lost);
        end
        checks++; if (n3 !== 2) begin errors++; $display("FAIL coll_count: got %0d want 2", n3); end
        checks++; if (lost_seen !== 0) begin errors++; $display("FAIL coll_lost: got %0d want 0", lost_seen); end
        checks++; if (pending !== '0) begin errors++; $display("FAIL coll_pending: got %h want 0", pending); end
    endtask

    task automatic test_reset_mid();
        int nv = 0;
        logic [NB-1:0] exp_p;
        exp_p = '0;
        exp_p[4:3] = 2'b11;
        do_reset();
        ready = 1'b0;
        ev[4:0] = 5'h1F;
        step();
        ev = '0;
        repeat (3) step();
        checks++; if (valid !== 1'b1 || pending !== exp_p) begin errors++; $display("FAIL rmid_pre: got v=%b p=%h want v=1 p=%h", valid, pending, exp_p); end
        rst_n = 1'b0;
        #1;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", valid); end
        checks++; if (pending !== '0) begin errors++; $display("FAIL rmid_pending: got %h want 0", pending); end
        checks++; if (data !== 8'd0) begin errors++; $display("FAIL rmid_data: got %0d want 0", data); end
        model_reset();
        step();
        step();
        rst_n = 1'b1;
        ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            nv += int'(valid);
            step();
        end
        checks++; if (nv !== 0) begin errors++; $display("FAIL rmid_after: got %0d valid cycles want 0", nv); end
    endtask

    task automatic test_random();
        evt_id_t exp_d;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            en = ($urandom_range(0, 9) != 0);
            ready = ($urandom_range(0, 3) != 0);
            lost_clr = ($urandom_range(0, 19) == 0);
            ev = '0;
            if ($urandom_range(0, 1) == 0) begin
                for (int j = $urandom_range(0, 2); j > 0; j--)
                    ev[$urandom_range(0, 7)] = 1'b1;
            end else if ($urandom_range(0, 2) == 0) begin
                ev[$urandom_range(0, NB - 1)] = 1'b1;
            end
            step();
            exp_d = (m_q.size() > 0) ? evt_id_t'(m_q[0]) : evt_id_t'(m_last);
            checks++; if (valid !== (m_q.size() > 0)) begin errors++; $display("FAIL rnd_valid@%0d: got %b want %b", c, valid, m_q.size() > 0); end
            checks++; if (data !== exp_d) begin errors++; $display("FAIL rnd_data@%0d: got %0d want %0d", c, data, exp_d); end
            checks++; if (pending !== model_pend_vec()) begin errors++; $display("FAIL rnd_pending@%0d: got %h want %h", c, pending, model_pend_vec()); end
            checks++; if (lost !== m_lost) begin errors++; $display("FAIL rnd_lost@%0d: got %b want %b", c, lost, m_lost); end
`ifdef FC_EVT_LOST_CNT_EN
            checks++; if (lost_cnt !== 16'(m_cnt)) begin errors++; $display("FAIL rnd_lost_cnt@%0d: got %0d want %0d", c, lost_cnt, m_cnt); end
`endif
        end
        lost_clr = 1'b0;
        ev = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_lost();
        test_collision();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
